// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity types and line idle level.
// The transmitter and the receiver both import this package.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic PAR_EVEN   = 1'b0;
   localparam logic PAR_ODD    = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   localparam int PRESCALE_W = 6;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..prescale-1 while enabled and pulses tick on the terminal count.
// A prescale of 0 makes the 6-bit terminal value 63, so each bit lasts 64 cycles.
module uart_tx_bit_timer
   import uart_pkg::*;
(
   input  logic                  clk,
   input  logic                  srst,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  en,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_reg;
   logic [PRESCALE_W-1:0] term_cnt;

   assign term_cnt = prescale - PRESCALE_W'(1);
   assign tick     = en && (cnt_reg == term_cnt);

   always_ff @(posedge clk) begin
      if (srst || !en) begin
         cnt_reg <= '0;
      end else if (tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frm.sv
// UART transmitter: frames a parallel byte as start, LSB-first data, optional parity and stop,
// with all frame settings captured on accept and every output registered.
module uart_tx_frm
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  DATA_VALID,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic                  TX_OUT,
   output logic                  Busy
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   state_t                state_reg;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [IDX_W-1:0]      bit_idx_reg;
   logic                  par_en_reg;
   logic                  par_bit_reg;
   logic [PRESCALE_W-1:0] prescale_reg;
   logic                  tx_reg;
   logic                  busy_reg;
   logic                  timer_en;
   logic                  tick;

   assign timer_en = (state_reg != IDLE);
   assign TX_OUT   = tx_reg;
   assign Busy     = busy_reg;

   uart_tx_bit_timer u_bit_timer (
      .clk      (CLK),
      .srst     (RST),
      .prescale (prescale_reg),
      .en       (timer_en),
      .tick     (tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         bit_idx_reg  <= '0;
         par_en_reg   <= 1'b0;
         par_bit_reg  <= 1'b0;
         prescale_reg <= '0;
         tx_reg       <= IDLE_LEVEL;
         busy_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (DATA_VALID) begin
                  // Parity is resolved here so the payload register is free to shift.
                  shift_reg    <= P_DATA;
                  par_en_reg   <= PAR_EN;
                  par_bit_reg  <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
                  prescale_reg <= Prescale;
                  tx_reg       <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= shift_reg >> 1;
                  bit_idx_reg <= '0;
                  state_reg   <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_idx_reg == IDX_W'(DATA_WIDTH - 1)) begin
                     if (par_en_reg) begin
                        tx_reg    <= par_bit_reg;
                        state_reg <= PARITY;
                     end else begin
                        tx_reg    <= IDLE_LEVEL;
                        state_reg <= STOP;
                     end
                  end else begin
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= shift_reg >> 1;
                     bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  tx_reg    <= IDLE_LEVEL;
                  state_reg <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  tx_reg    <= IDLE_LEVEL;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end
            end
            default: begin
               tx_reg    <= IDLE_LEVEL;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frm.sv
// Self-checking bench for uart_tx_frm: directed frame table, drop/reset corner cases and
// random frames decoded by a sampling receiver model that works from the frame rules alone.
module tb_uart_tx_frm;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] P_DATA = 8'h00;
   logic       DATA_VALID = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic       TX_OUT;
   logic       Busy;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   uart_tx_frm #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic [5:0] ps;
      int         busy;
      logic       par;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Sends one frame, records the line while Busy is high, then compares the trace against
   // the ideal waveform and decodes it by sampling mid-bit like a receiver would.
   task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] ps, input int inject_at, input logic [7:0] inj,
                            output int nbusy, output logic [7:0] rx_d, output logic rx_par,
                            output logic rx_stop, output logic wave_ok);
      logic q[$];
      logic exp_bits[$];
      int   p_eff;
      int   idx;
      @(negedge CLK);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      nbusy = 0;
      while (Busy === 1'b1 && nbusy < 5000) begin
         q.push_back(TX_OUT);
         nbusy++;
         @(negedge CLK);
         if (nbusy == inject_at) begin
            P_DATA = inj; DATA_VALID = 1'b1;
         end else if (nbusy == inject_at + 1) begin
            DATA_VALID = 1'b0;
         end
      end
      DATA_VALID = 1'b0;
      p_eff = (ps == 6'd0) ? 64 : int'(ps);
      exp_bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_bits.push_back(d[k]);
      if (pe) exp_bits.push_back(logic'(($countones(d) % 2 == 1) != pt));
      exp_bits.push_back(1'b1);
      wave_ok = (q.size() == exp_bits.size() * p_eff) && (TX_OUT === 1'b1);
      for (int i = 0; i < q.size(); i++) begin
         if (i / p_eff < exp_bits.size() && q[i] !== exp_bits[i / p_eff]) wave_ok = 1'b0;
      end
      rx_d = 8'hxx; rx_par = 1'bx; rx_stop = 1'bx;
      for (int k = 0; k < 8; k++) begin
         idx = p_eff * (1 + k) + p_eff / 2;
         if (idx < q.size()) rx_d[k] = q[idx];
      end
      idx = p_eff * 9 + p_eff / 2;
      if (pe && idx < q.size()) rx_par = q[idx];
      idx = p_eff * (pe ? 10 : 9) + p_eff / 2;
      if (idx < q.size()) rx_stop = q[idx];
   endtask

   initial begin
      int         nbusy;
      logic [7:0] rx_d;
      logic       rx_par;
      logic       rx_stop;
      logic       wave_ok;
      logic       stayed_idle;
      logic [7:0] d;
      logic       pe, pt;
      logic [5:0] ps;
      logic [5:0] ps_tab[6];

      vecs[0] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, ps: 6'd8,  busy: 88,  par: 1'b0};
      vecs[1] = '{d: 8'h01, pe: 1'b1, pt: 1'b1, ps: 6'd16, busy: 176, par: 1'b0};
      vecs[2] = '{d: 8'hFF, pe: 1'b0, pt: 1'b0, ps: 6'd8,  busy: 80,  par: 1'b0};
      vecs[3] = '{d: 8'h00, pe: 1'b1, pt: 1'b1, ps: 6'd1,  busy: 11,  par: 1'b1};
      vecs[4] = '{d: 8'h7F, pe: 1'b1, pt: 1'b0, ps: 6'd3,  busy: 33,  par: 1'b1};
      vecs[5] = '{d: 8'h80, pe: 1'b0, pt: 1'b1, ps: 6'd0,  busy: 640, par: 1'b0};
      vecs[6] = '{d: 8'h6E, pe: 1'b1, pt: 1'b1, ps: 6'd63, busy: 693, par: 1'b0};
      ps_tab  = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};

      repeat (3) @(negedge CLK);
      check("reset_tx", 32'(TX_OUT), 32'd1);
      check("reset_busy", 32'(Busy), 32'd0);
      RST = 1'b0;
      @(negedge CLK);

      for (int v = 0; v < 7; v++) begin
         run_frame(vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].ps, -5, 8'h00,
                   nbusy, rx_d, rx_par, rx_stop, wave_ok);
         $display("vec %0d: data=%02h pe=%0b pt=%0b ps=%0d busy=%0d rx=%02h",
                  v, vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].ps, nbusy, rx_d);
         check("vec_busy_len", 32'(nbusy), 32'(vecs[v].busy));
         check("vec_wave", 32'(wave_ok), 32'd1);
         check("vec_rx_data", 32'(rx_d), 32'(vecs[v].d));
         if (vecs[v].pe) check("vec_parity", 32'(rx_par), 32'(vecs[v].par));
         check("vec_stop", 32'(rx_stop), 32'd1);
      end

      // A request arriving mid-frame must be dropped, not queued.
      run_frame(8'h5A, 1'b0, 1'b0, 6'd8, 20, 8'h3C, nbusy, rx_d, rx_par, rx_stop, wave_ok);
      stayed_idle = 1'b1;
      repeat (100) begin
         @(negedge CLK);
         if (Busy !== 1'b0 || TX_OUT !== 1'b1) stayed_idle = 1'b0;
      end
      $display("drop: sent=5a busy=%0d rx=%02h idle_after=%0b", nbusy, rx_d, stayed_idle);
      check("drop_rx_data", 32'(rx_d), 32'h5A);
      check("drop_wave", 32'(wave_ok), 32'd1);
      check("drop_idle", 32'(stayed_idle), 32'd1);
      run_frame(8'h3C, 1'b0, 1'b0, 6'd8, -5, 8'h00, nbusy, rx_d, rx_par, rx_stop, wave_ok);
      $display("after drop: sent=3c busy=%0d rx=%02h", nbusy, rx_d);
      check("after_drop_rx", 32'(rx_d), 32'h3C);

      // Reset in the middle of data bit 3 aborts the frame on the next edge.
      @(negedge CLK);
      P_DATA = 8'hC3; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd8; DATA_VALID = 1'b1;
      @(negedge CLK);
      DATA_VALID = 1'b0;
      repeat (35) @(negedge CLK);
      check("mid_busy", 32'(Busy), 32'd1);
      check("mid_bit3", 32'(TX_OUT), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      $display("mid reset: tx=%0b busy=%0b", TX_OUT, Busy);
      check("rst_mid_tx", 32'(TX_OUT), 32'd1);
      check("rst_mid_busy", 32'(Busy), 32'd0);
      RST = 1'b0;
      run_frame(8'h96, 1'b1, 1'b1, 6'd8, -5, 8'h00, nbusy, rx_d, rx_par, rx_stop, wave_ok);
      $display("post reset: sent=96 busy=%0d rx=%02h", nbusy, rx_d);
      check("post_rst_busy", 32'(nbusy), 32'd88);
      check("post_rst_wave", 32'(wave_ok), 32'd1);
      check("post_rst_rx", 32'(rx_d), 32'h96);

      for (int n = 0; n < 256; n++) begin
         d  = 8'($urandom);
         pe = 1'($urandom);
         pt = 1'($urandom);
         ps = ps_tab[$urandom_range(0, 5)];
         run_frame(d, pe, pt, ps, -5, 8'h00, nbusy, rx_d, rx_par, rx_stop, wave_ok);
         $display("rand %0d: data=%02h pe=%0b pt=%0b ps=%0d busy=%0d rx=%02h",
                  n, d, pe, pt, ps, nbusy, rx_d);
         check("rand_rx_data", 32'(rx_d), 32'(d));
         check("rand_wave", 32'(wave_ok), 32'd1);
         check("rand_busy_len", 32'(nbusy), 32'((10 + int'(pe)) * int'(ps)));
         if (pe) check("rand_parity_err", 32'(($countones(d) + int'(rx_par)) % 2), 32'(pt));
         check("rand_stop_err", 32'(rx_stop), 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
